punc_control: RTL and testbench
===============================

Name: punc_control

Overview:
- Control unit for the PUnC LC3 processor; the other end of the datapath control interface.
- Receives the latched instruction word and NZP flags from the datapath; drives every datapath select, load and write-enable.
- Multi-cycle FSM: FETCH, DECODE, EXEC, an extra EXEC2 for indirect memory ops, and a terminal HALT.

Parameters:
- PC_INIT, 16'h0000, PC value requested via pc_clr on reset exit.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir  in  16  instruction register contents from the datapath.
- n, z, p  in  1 each  datapath condition-code flags.
- pc_clr  out  1  clear PC to PC_INIT.
- pc_ld  out  1  load PC.
- pc_inc  out  1  PC <= PC+1.
- pc_data_sel  out  1  PC load source: 0 = ALU, 1 = RF port 0.
- ir_ld  out  1  IR <= mem read data.
- mem_addr_sel  out  2  memory address: 00 = PC, 01 = ALU, 10 = store register.
- mem_w_en  out  1  memory write; data comes from RF port 1.
- store_ld  out  1  store register <= mem read data.
- rf_r_addr_0, rf_r_addr_1  out  3 each  RF read addresses.
- rf_w_addr  out  3  RF write address.
- rf_w_en  out  1  RF write enable.
- rf_w_sel  out  2  RF write data: 00 = PC, 01 = mem data, 10 = ALU.
- alu_a_sel  out  1  0 = PC, 1 = RF port 0.
- alu_b_sel  out  1  0 = RF port 1, 1 = sext_data.
- alu_op  out  2  00 = ADD, 01 = AND, 10 = PASS_A, 11 = NOT.
- sext_data  out  16  sign-extended immediate.
- nzp_ld  out  1  update NZP flags.
- nzp_sel  out  1  flag source: 0 = ALU, 1 = mem data.
- halted  out  1  high in HALT.

Behaviour:
- Reset:
  - rst low forces state RST_EXIT.
  - While rst is low, every output is 0.
- RST_EXIT (one cycle):
  - pc_clr = 1, all else 0.
  - Next state FETCH.
- FETCH:
  - mem_addr_sel = 00, ir_ld = 1, pc_inc = 1.
  - Next state DECODE.
- DECODE:
  - All enables 0; the IR is stable this cycle.
  - Opcode 1111 goes to HALT; every other opcode goes to EXEC.
- EXEC:
  - Acts on ir[15:12] as listed below.
  - Next state is EXEC2 for LDI/STI, otherwise FETCH.
- Outputs are combinational from state and ir. Any unlisted enable is 0; unlisted selects are don't-care, driven 0.
- PC-relative targets use the already-incremented PC.
- sext_data: off11 = ir[10:0] for JSR, off9 = ir[8:0], off6 = ir[5:0], imm5 = ir[4:0]; each sign-extended to 16 bits.
- EXEC actions by opcode:
  - ADD (0001) / AND (0101): rf_r_addr_0 = ir[8:6]; alu_a_sel = 1. If ir[5] = 1, alu_b_sel = 1 with imm5; otherwise alu_b_sel = 0 with rf_r_addr_1 = ir[2:0]. alu_op = ADD or AND. rf_w_sel = ALU, rf_w_addr = ir[11:9], rf_w_en = 1, nzp_ld = 1, nzp_sel = 0.
  - NOT (1001): A = RF0 ir[8:6], alu_op = NOT; write back and NZP as for ADD.
  - BR (0000): ALU = PC + off9. pc_ld = 1 only if (ir[11]&n) | (ir[10]&z) | (ir[9]&p). nzp = 000 never branches.
  - JMP (1100): rf_r_addr_0 = ir[8:6], pc_data_sel = 1, pc_ld = 1.
  - JSR/JSRR (0100):
    - rf_w_addr = 7, rf_w_sel = PC, rf_w_en = 1.
    - ir[11] = 1: PC <= PC + off11. ir[11] = 0: PC <= RF0 at ir[8:6].
    - Both happen on the same edge; JSRR R7 uses the old R7.
  - LD (0010): mem addr = ALU (PC + off9); write mem data to ir[11:9]; nzp_ld = 1, nzp_sel = 1.
  - LDR (0110): as LD, but ALU = RF0 at ir[8:6] + off6.
  - LEA (1110): rf_w_sel = ALU (PC + off9), rf_w_en = 1, nzp_ld = 1, nzp_sel = 0.
  - ST (0011): mem addr = ALU (PC + off9), rf_r_addr_1 = ir[11:9], mem_w_en = 1.
  - STR (0111): as ST, but ALU = RF0 at ir[8:6] + off6.
  - LDI (1010) / STI (1011): mem addr = ALU (PC + off9), store_ld = 1.
  - 1000 and 1101: no-op.
- EXEC2:
  - mem_addr_sel = 10.
  - LDI: write mem data to ir[11:9], nzp_ld = 1, nzp_sel = 1.
  - STI: rf_r_addr_1 = ir[11:9], mem_w_en = 1.
- HALT: halted = 1, all enables 0; exits only via reset.
- Cycle counts: 3 cycles per instruction, 4 for LDI/STI. RST_EXIT costs 1 cycle once.
- Reset mid-instruction: no partial enable may be issued once rst falls; the FSM restarts from RST_EXIT.

Test Plan:
- Reset release, then mem[0] = 16'h1261 (ADD R1,R1,#1) with R1 = 5 -> pc_clr for 1 cycle; R1 = 6; P = 1; PC = 1 after 4 cycles.
- BRz +3 (16'h0403) at PC 0x10 with Z = 1 -> PC = 0x14. Same instruction with Z = 0 -> PC = 0x11. nzp field 000 -> never taken.
- LDI R2 with mem[0x21] = 0x0030, mem[0x30] = 16'h8000 at PC 0x20, off9 = 0 -> R2 = 0x8000, N = 1, 4 cycles, store_ld pulses in EXEC.
- JSRR R7 (16'h41C0) with R7 = 0x0050 at PC 0x40 -> PC = 0x0050, R7 = 0x0041.
- STR R3,R4,#-1 with R4 = 0x100, R3 = 0xBEEF -> mem[0xFF] = 0xBEEF; mem_w_en high exactly 1 cycle.
- TRAP 16'hF025 -> halted = 1 and stays high, PC frozen. Assert rst during an LDI EXEC2 -> no mem/rf write; after release, fetch from PC_INIT.

Source files
------------

// File: rtl/punc_control.sv
// rtl/punc_control.sv - PUnC LC3 control unit: multi-cycle FSM driving the datapath selects and enables
module punc_control #(
  parameter logic [15:0] PC_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_clr,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_data_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        store_ld,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic [15:0] sext_data,
  output logic        nzp_ld,
  output logic        nzp_sel,
  output logic        halted
);

  typedef enum logic [2:0] {RST_EXIT, FETCH, DECODE, EXEC, EXEC2, HALT} state_t;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b11;
  localparam logic [1:0] MA_PC = 2'b00, MA_ALU = 2'b01, MA_STORE = 2'b10;
  localparam logic [1:0] WS_PC = 2'b00, WS_MEM = 2'b01, WS_ALU = 2'b10;

  state_t      state, state_next;
  logic [3:0]  opcode;
  logic [15:0] off11, off9, off6, imm5;

  assign opcode = ir[15:12];
  assign off11  = {{5{ir[10]}}, ir[10:0]};
  assign off9   = {{7{ir[8]}}, ir[8:0]};
  assign off6   = {{10{ir[5]}}, ir[5:0]};
  assign imm5   = {{11{ir[4]}}, ir[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_EXIT;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_clr       = 1'b0;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_data_sel  = 1'b0;
    ir_ld        = 1'b0;
    mem_addr_sel = MA_PC;
    mem_w_en     = 1'b0;
    store_ld     = 1'b0;
    rf_r_addr_0  = 3'd0;
    rf_r_addr_1  = 3'd0;
    rf_w_addr    = 3'd0;
    rf_w_en      = 1'b0;
    rf_w_sel     = WS_PC;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    sext_data    = 16'h0000;
    nzp_ld       = 1'b0;
    nzp_sel      = 1'b0;
    halted       = 1'b0;
    // Outputs stay quiet for the whole reset so a partially executed op never commits.
    if (rst) begin
      case (state)
        RST_EXIT: begin
          pc_clr     = 1'b1;
          state_next = FETCH;
        end
        FETCH: begin
          ir_ld      = 1'b1;
          pc_inc     = 1'b1;
          state_next = DECODE;
        end
        DECODE: state_next = (opcode == OP_TRAP) ? HALT : EXEC;
        EXEC: begin
          state_next = (opcode == OP_LDI || opcode == OP_STI) ? EXEC2 : FETCH;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              rf_r_addr_0 = ir[8:6];
              alu_a_sel   = 1'b1;
              if (opcode == OP_NOT) begin
                alu_op = ALU_NOT;
              end else begin
                alu_op = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                if (ir[5]) begin
                  alu_b_sel = 1'b1;
                  sext_data = imm5;
                end else begin
                  rf_r_addr_1 = ir[2:0];
                end
              end
              rf_w_sel  = WS_ALU;
              rf_w_addr = ir[11:9];
              rf_w_en   = 1'b1;
              nzp_ld    = 1'b1;
            end
            OP_BR: begin
              alu_b_sel = 1'b1;
              sext_data = off9;
              pc_ld     = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
            end
            OP_JMP: begin
              rf_r_addr_0 = ir[8:6];
              pc_data_sel = 1'b1;
              pc_ld       = 1'b1;
            end
            OP_JSR: begin
              // R7 captures the incremented PC on the same edge PC moves, so JSRR R7 reads the old R7.
              rf_w_addr = 3'd7;
              rf_w_sel  = WS_PC;
              rf_w_en   = 1'b1;
              pc_ld     = 1'b1;
              if (ir[11]) begin
                alu_b_sel = 1'b1;
                sext_data = off11;
              end else begin
                rf_r_addr_0 = ir[8:6];
                pc_data_sel = 1'b1;
              end
            end
            OP_LD, OP_LDR: begin
              alu_b_sel    = 1'b1;
              sext_data    = off9;
              if (opcode == OP_LDR) begin
                rf_r_addr_0 = ir[8:6];
                alu_a_sel   = 1'b1;
                sext_data   = off6;
              end
              mem_addr_sel = MA_ALU;
              rf_w_sel     = WS_MEM;
              rf_w_addr    = ir[11:9];
              rf_w_en      = 1'b1;
              nzp_ld       = 1'b1;
              nzp_sel      = 1'b1;
            end
            OP_LEA: begin
              alu_b_sel = 1'b1;
              sext_data = off9;
              rf_w_sel  = WS_ALU;
              rf_w_addr = ir[11:9];
              rf_w_en   = 1'b1;
              nzp_ld    = 1'b1;
            end
            OP_ST, OP_STR: begin
              alu_b_sel    = 1'b1;
              sext_data    = off9;
              if (opcode == OP_STR) begin
                rf_r_addr_0 = ir[8:6];
                alu_a_sel   = 1'b1;
                sext_data   = off6;
              end
              mem_addr_sel = MA_ALU;
              rf_r_addr_1  = ir[11:9];
              mem_w_en     = 1'b1;
            end
            OP_LDI, OP_STI: begin
              alu_b_sel    = 1'b1;
              sext_data    = off9;
              mem_addr_sel = MA_ALU;
              store_ld     = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC2: begin
          mem_addr_sel = MA_STORE;
          state_next   = FETCH;
          if (opcode == OP_LDI) begin
            rf_w_sel  = WS_MEM;
            rf_w_addr = ir[11:9];
            rf_w_en   = 1'b1;
            nzp_ld    = 1'b1;
            nzp_sel   = 1'b1;
          end else begin
            rf_r_addr_1 = ir[11:9];
            mem_w_en    = 1'b1;
          end
        end
        HALT: halted = 1'b1;
        default: state_next = RST_EXIT;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - directed bench: behavioural LC3 datapath around punc_control
module tb_punc_control;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dp_ir = 16'h1261;
  logic        dp_n = 1'b0, dp_z = 1'b0, dp_p = 1'b0;
  logic        pc_clr, pc_ld, pc_inc, pc_data_sel, ir_ld, mem_w_en, store_ld;
  logic [1:0]  mem_addr_sel, rf_w_sel, alu_op;
  logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_w_addr;
  logic        rf_w_en, alu_a_sel, alu_b_sel, nzp_ld, nzp_sel, halted;
  logic [15:0] sext_data;
  logic [43:0] outs;

  logic [15:0] pc = 16'h0000;
  logic [15:0] store_q = 16'h0000;
  logic [15:0] rf [0:7];
  logic [15:0] mem [0:255];
  int          compared = 0, mismatched = 0;
  int          w_cnt, s_cnt;

  always #5 clk = ~clk;

  punc_control #(.PC_INIT(16'h0000)) dut (
    .clk(clk), .rst(rst), .ir(dp_ir), .n(dp_n), .z(dp_z), .p(dp_p),
    .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_data_sel(pc_data_sel),
    .ir_ld(ir_ld), .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en), .store_ld(store_ld),
    .rf_r_addr_0(rf_r_addr_0), .rf_r_addr_1(rf_r_addr_1), .rf_w_addr(rf_w_addr),
    .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .sext_data(sext_data), .nzp_ld(nzp_ld), .nzp_sel(nzp_sel), .halted(halted)
  );

  assign outs = {pc_clr, pc_ld, pc_inc, pc_data_sel, ir_ld, mem_addr_sel, mem_w_en, store_ld,
                 rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel, alu_a_sel, alu_b_sel,
                 alu_op, sext_data, nzp_ld, nzp_sel, halted};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One datapath clock: sample controls at negedge, commit just after the rising edge.
  task automatic step();
    logic [15:0] rf0, rf1, a, b, y, maddr, mdata, pc_n, nzp_v, wdata;
    logic        do_ir, do_st, do_mw, do_rw, do_nzp;
    logic [2:0]  waddr;
    @(negedge clk);
    rf0 = rf[rf_r_addr_0];
    rf1 = rf[rf_r_addr_1];
    a = alu_a_sel ? rf0 : pc;
    b = alu_b_sel ? sext_data : rf1;
    case (alu_op)
      2'b00:   y = a + b;
      2'b01:   y = a & b;
      2'b10:   y = a;
      default: y = ~a;
    endcase
    maddr = (mem_addr_sel == 2'b00) ? pc : (mem_addr_sel == 2'b01) ? y : store_q;
    mdata = mem[maddr[7:0]];
    pc_n  = pc_clr ? 16'h0000 : pc_ld ? (pc_data_sel ? rf0 : y) : pc_inc ? pc + 16'd1 : pc;
    wdata = (rf_w_sel == 2'b00) ? pc : (rf_w_sel == 2'b01) ? mdata : y;
    nzp_v = nzp_sel ? mdata : y;
    do_ir = ir_ld; do_st = store_ld; do_mw = mem_w_en; do_rw = rf_w_en; do_nzp = nzp_ld;
    waddr = rf_w_addr;
    if (mem_w_en) w_cnt++;
    if (store_ld) s_cnt++;
    @(posedge clk);
    #1;
    pc = pc_n;
    if (do_ir) dp_ir = mdata;
    if (do_st) store_q = mdata;
    if (do_mw) mem[maddr[7:0]] = rf1;
    if (do_rw) rf[waddr] = wdata;
    if (do_nzp) begin
      dp_n = nzp_v[15];
      dp_z = (nzp_v == 16'h0000);
      dp_p = !nzp_v[15] && (nzp_v != 16'h0000);
    end
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1261;
    rf[1]  = 16'h0005;
    #2;
    check_eq("reset_outs_zero", outs, 0);

    // ADD R1,R1,#1 from reset release
    @(posedge clk); #1 rst = 1'b1; #1;
    check_eq("rst_exit_outs", outs, 44'h80000000000);
    step();
    check_eq("fetch_pc_inc", {ir_ld, pc_inc, mem_addr_sel}, 4'b1100);
    step();
    check_eq("decode_outs_zero", outs, 0);
    steps(2);
    check_eq("add_r1", rf[1], 16'h0006);
    check_eq("add_nzp", {dp_n, dp_z, dp_p}, 3'b001);
    check_eq("add_pc", pc, 16'h0001);
    check_eq("add_back_in_fetch", ir_ld, 1'b1);

    // BRz +3: taken, not taken, nzp=000
    pc = 16'h0010; mem[16'h10] = 16'h0403; dp_n = 1'b0; dp_z = 1'b1; dp_p = 1'b0;
    steps(3);
    check_eq("brz_taken_pc", pc, 16'h0014);
    pc = 16'h0010; dp_z = 1'b0; dp_p = 1'b1;
    steps(3);
    check_eq("brz_not_taken_pc", pc, 16'h0011);
    pc = 16'h0010; mem[16'h10] = 16'h0003; dp_n = 1'b1; dp_z = 1'b1; dp_p = 1'b1;
    steps(3);
    check_eq("br_nzp000_pc", pc, 16'h0011);

    // LDI R2 through 0x21 -> 0x30
    pc = 16'h0020; mem[16'h20] = 16'hA400; mem[16'h21] = 16'h0030; mem[16'h30] = 16'h8000;
    s_cnt = 0;
    steps(2);
    check_eq("ldi_exec_store_ld", {store_ld, mem_addr_sel, rf_w_en}, 4'b1010);
    step();
    check_eq("ldi_exec2_sel", {store_ld, mem_addr_sel, rf_w_en, nzp_sel}, 5'b01011);
    step();
    check_eq("ldi_r2", rf[2], 16'h8000);
    check_eq("ldi_nzp", {dp_n, dp_z, dp_p}, 3'b100);
    check_eq("ldi_store_pulses", s_cnt, 1);
    check_eq("ldi_4cyc_fetch", ir_ld, 1'b1);

    // JSRR R7
    pc = 16'h0040; mem[16'h40] = 16'h41C0; rf[7] = 16'h0050;
    steps(3);
    check_eq("jsrr_pc", pc, 16'h0050);
    check_eq("jsrr_r7", rf[7], 16'h0041);

    // STR R3,R4,#-1
    pc = 16'h0060; mem[16'h60] = 16'h773F; rf[4] = 16'h0100; rf[3] = 16'hBEEF; mem[16'hFF] = 16'h0000;
    w_cnt = 0;
    steps(3);
    check_eq("str_mem", mem[16'hFF], 16'hBEEF);
    check_eq("str_w_pulses", w_cnt, 1);

    // LEA R5,#-2
    pc = 16'h0070; mem[16'h70] = 16'hEBFE; dp_n = 1'b1; dp_z = 1'b0; dp_p = 1'b0;
    steps(3);
    check_eq("lea_r5", rf[5], 16'h006F);
    check_eq("lea_nzp", {dp_n, dp_z, dp_p}, 3'b001);

    // TRAP halts
    pc = 16'h0080; mem[16'h80] = 16'hF025;
    steps(3);
    check_eq("halt_outs", outs, 44'h1);
    steps(5);
    check_eq("halt_stays", outs, 44'h1);
    check_eq("halt_pc_frozen", pc, 16'h0081);

    // Reset in the middle of an LDI EXEC2
    rst = 1'b0; #1;
    mem[0] = 16'hA400; mem[1] = 16'h0030; rf[2] = 16'h1234;
    @(posedge clk); #1 rst = 1'b1; #1;
    steps(4);
    check_eq("ldi2_in_exec2", {mem_addr_sel, rf_w_en}, 3'b101);
    rst = 1'b0; #1;
    check_eq("rst_mid_outs_zero", outs, 0);
    step();
    check_eq("rst_mid_no_rf_write", rf[2], 16'h1234);
    @(posedge clk); #1 rst = 1'b1; #1;
    check_eq("rst_mid_pc_clr", outs, 44'h80000000000);
    step();
    check_eq("refetch_pc_init", pc, 16'h0000);
    check_eq("refetch_fetch", {ir_ld, mem_addr_sel}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
